// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding one registered output stage.
//
// Picks one of N_CH producers per cycle by round-robin. The search starts just
// after the channel that won the last transfer. The chosen word goes into a
// single output register with a valid/ready handshake. Throughput is one word
// per cycle, and the latency from input transfer to out_valid is 1 cycle.
//
// Optional build macro: RR_ARB_MUX_FIXED_PRIO_EN
//   When defined, the lowest-index valid channel always wins and no rotation
//   pointer exists.
//   When undefined (the default), arbitration is round-robin.
//
// Parameters:
//   N_CH   number of input channels (>= 1, any value)
//   WIDTH  data width per channel
//   CH_W   derived channel-index width, max(1, $clog2(N_CH))
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   per-channel valid
//   in_data    packed channel data; channel k is in_data[k*WIDTH +: WIDTH]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered selected word
//   out_ch     channel index that supplied out_data
//   out_ready  consumer accepts out_data this cycle
module rr_arb_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  logic             load;
  logic             xfer;
  logic             gnt_found;
  logic [CH_W-1:0]  gnt_ch;
  logic [WIDTH-1:0] gnt_data;

  assign load = ~out_valid | out_ready;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN

  // Fixed priority: the lowest valid index wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    gnt_data  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (in_valid[k] && !gnt_found) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_W'(k);
        gnt_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

`else

  logic [CH_W-1:0] ptr;

  // The rotating scan ptr+1 .. N_CH-1, 0 .. ptr is split into two fixed-order
  // searches. The first search looks for the lowest valid index above ptr.
  // The second looks for the lowest valid index at or below ptr. The first
  // search wins when it finds a requester. This keeps every index a loop
  // constant, so there is no variable-offset modulo logic.
  always_comb begin
    logic             hi_found;
    logic             lo_found;
    logic [CH_W-1:0]  hi_ch;
    logic [CH_W-1:0]  lo_ch;
    logic [WIDTH-1:0] hi_data;
    logic [WIDTH-1:0] lo_data;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    hi_data  = '0;
    lo_data  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (in_valid[k]) begin
        if (CH_W'(k) > ptr) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_ch    = CH_W'(k);
            hi_data  = in_data[k*WIDTH +: WIDTH];
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_ch    = CH_W'(k);
          lo_data  = in_data[k*WIDTH +: WIDTH];
        end
      end
    end
    gnt_found = hi_found | lo_found;
    gnt_ch    = hi_found ? hi_ch   : lo_ch;
    gnt_data  = hi_found ? hi_data : lo_data;
  end

  // Priority rotates only on a real transfer, never on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= CH_W'(N_CH - 1);
    end else if (xfer) begin
      ptr <= gnt_ch;
    end
  end

`endif

  // in_ready is held low while reset is asserted, so nothing is offered mid-reset.
  assign xfer = load & gnt_found & ~rst;

  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      in_ready[k] = xfer && (gnt_ch == CH_W'(k));
    end
  end

  // On a drain with no new transfer, only out_valid clears.
  // out_data and out_ch keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt_ch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: self-checking bench for rr_arb_mux in the default round-robin
// build (N_CH=4, WIDTH=8).
// Directed steps are followed by a random phase. Both are checked against a
// behavioural model that holds the output word and the last granted channel.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_ready;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_last;

  rr_arb_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The next winner is the first requester found by walking forward from the
  // last winner, modulo N. The result is -1 when no grant is given this cycle.
  function automatic int model_grant();
    if (m_valid && !out_ready) return -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_last + i) % N;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_last  = N - 1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  // Called just after a negedge with the inputs already driven. It checks
  // in_ready, steps the model on the posedge, checks the registered outputs,
  // and returns at the next negedge.
  task automatic cyc();
    int g;
    logic [N-1:0] exp_rdy;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_ch    = g;
      m_last  = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
    @(negedge clk);
  endtask

  initial begin
    // Reset with requests pending: no grant may be offered.
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_data(8'h01, 8'h02, 8'h03, 8'h04);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single channel, then drain.
    in_valid = 4'b0100;
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    cyc();
    chk("single_ch", 32'(out_ch), 32'd2);
    in_valid = 4'b0000;
    cyc();

    // Rotation with every channel requesting.
    in_valid = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 6; i++) cyc();

    // Back-pressure: stall for 5 cycles, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Wrap and skip: win on ch3, then only ch0/ch2 request.
    in_valid = 4'b1000;
    cyc();
    chk("wrap_last3", 32'(out_ch), 32'd3);
    in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) cyc();

    // Async reset between edges while out_valid is high.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    cyc();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_data", 32'(out_data), 32'h0);
    chk("arst_out_ch", 32'(out_ch), 32'h0);
    model_reset();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b0110;
    cyc();
    chk("arst_first", 32'(out_ch), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel successor to the team's 2:1 mux.
- Selects one of N_CH valid/ready input channels by round-robin arbitration instead of an external select.
- Forwards the selected word through a single registered output stage with valid/ready handshake.
- Sits between multiple producers and one shared consumer (bus/port sharing).

Parameters:
- N_CH, 4, number of input channels (>=1; need not be a power of two).
- WIDTH, 8, data width per channel in bits.
- CH_W (localparam, not overridable), derived: max(1, $clog2(N_CH)); width of the channel-index output.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, N_CH, per-channel valid; bit k belongs to channel k.
- in_data, input, N_CH*WIDTH, packed data; channel k is in_data[k*WIDTH +: WIDTH].
- in_ready, output, N_CH, per-channel ready; at most one bit set (one-hot or zero).
- out_valid, output, 1, output register holds a word.
- out_data, output, WIDTH, registered selected word.
- out_ch, output, CH_W, index of the channel that supplied out_data.
- out_ready, input, 1, consumer accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0, out_data=0, out_ch=0, in_ready=0.
  - Round-robin pointer ptr=N_CH-1, so channel 0 has first priority after reset.
- load = ~out_valid | out_ready. The output register may take a new word this cycle.
- Grant search (combinational): scan channels ptr+1, ptr+2, … wrapping N_CH-1 -> 0, ending at ptr. The first k with in_valid[k]=1 is the grant.
- in_ready[k]=1 only when load=1 and k is the grant. in_ready may depend combinationally on in_valid and out_ready; no combinational path exists from in_data.
- Transfer on channel k: in_valid[k] & in_ready[k]. On the next edge:
  - out_data <= in_data[k], out_ch <= k, out_valid <= 1, ptr <= k.
- Output drain: out_valid & out_ready with no new transfer -> out_valid <= 0. out_data and out_ch hold their last values (not cleared).
- Simultaneous drain and transfer: the new word replaces the old one in the same edge. Throughput is one word per cycle, no bubble.
- Stall: out_valid=1 & out_ready=0 -> in_ready=0 on all channels. out_data, out_ch and ptr hold.
- Latency: exactly 1 cycle from input transfer to out_valid.
- ptr changes only on a transfer. Idle cycles do not rotate priority.
- A requester never waits more than N_CH-1 grants to other channels (fairness bound).
- N_CH=1: the grant is always channel 0, out_ch=0, and the block degenerates to a registered pipeline stage.
- Inputs are not required to hold valid without ready. The block does not check this.
- Reset asserted mid-transfer: any in-flight word is discarded, all outputs return to reset values immediately, and ptr returns to N_CH-1.

Optional Feature:
- Macro RR_ARB_MUX_FIXED_PRIO_EN.
- Defined:
  - Grant uses fixed priority: the lowest index with in_valid wins.
  - ptr is not implemented; there is no rotation.
  - Other behaviour is unchanged; starvation of high indices is permitted.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset then single channel: release rst, out_ready=1, in_valid=4'b0100, in_data ch2=8'hA5 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- Round-robin rotation: all in_valid=4'b1111 held, data ch k = 8'h10+k, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, out_data 8'h10,8'h11,8'h12,8'h13,…; one word per cycle.
- Back-pressure:
  - out_ready=0 with out_valid=1 -> in_ready=4'b0000, and out_data/out_ch hold for 5 cycles.
  - Raise out_ready -> the held word drains and the next grant follows the rotation order.
- Wrap and skip: last grant ch3, then in_valid=4'b0101 -> grant ch0; next grant ch2; next ch0.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately. The first grant after release goes to the lowest valid channel.
- Fixed-priority build (RR_ARB_MUX_FIXED_PRIO_EN defined), in_valid=4'b1010 held, out_ready=1 -> out_ch=1 every cycle; ch3 never granted.
